seg7_scan_capture: RTL
======================

// Module: seg7_scan_capture
// PURPOSE
//  Passive receiver for the multiplexed 8-digit 7-segment scan bus (SEG/AN) driven by seg7_scan8.
//  Watches the scan, decodes each digit's segment pattern back to a hex nibble, and rebuilds the full displayed word.
//  Used in-fabric as a self-check monitor and in benches as the scoreboard front end for display drivers.
// PARAMETERS
//  N_DIGITS    8   number of anodes/digits captured (1..8)
//  SETTLE_CYC  4   cycles {AN,SEG} must be unchanged before a sample is taken (>=1)
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   synchronous, active-low reset
//  SEG          in   7   segment bus, active-low, SEG[6:0] = {g,f,e,d,c,b,a}
//  AN           in   8   anode bus, active-low, one digit enabled at a time; AN[i] = digit i (i=0 is LSD)
//  value        out  32  last complete frame, nibble i = digit i; nibbles >= N_DIGITS read 0
//  frame_valid  out  1   1-cycle pulse when value updates
//  digit_seen   out  8   digits captured since last frame_valid
//  err_pattern  out  1   1-cycle pulse: settled SEG not in hex table while one anode active
//  err_anode    out  1   1-cycle pulse: settled AN has >1 bit low
// BEHAVIOUR
//  Reset (rst==0 at clk edge): value=0, frame_valid=0, digit_seen=0, err_*=0, settle counter=0, shadow=0.
//  Input stage: {AN,SEG} registered once (1 cycle). No CDC sync; inputs are same-clock.
//  Settle counter: reset to 0 when registered {AN,SEG} differs from previous cycle; else increments and saturates
//   at SETTLE_CYC. A sample fires exactly once per stable period, on the cycle the count reaches SETTLE_CYC.
//  On sample, AN classified:
//   - all ones (blank): ignored, no flags.
//   - exactly one low bit k, k < N_DIGITS: decode SEG; valid -> shadow[k]=nibble, digit_seen[k]=1;
//     invalid -> err_pattern pulse, shadow/digit_seen unchanged.
//   - one low bit k >= N_DIGITS: ignored.
//   - two or more low bits: err_anode pulse, no capture.
//  Decode table (SEG hex -> nibble): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9
//   08->A 03->B 46->C 21->D 06->E 0E->F. All other codes invalid (incl. 7F blank digit).
//  Repeated capture of a digit before frame completes overwrites shadow[k]; digit_seen stays 1.
//  Frame: the cycle after digit_seen[N_DIGITS-1:0] becomes all ones -> value<=shadow, frame_valid=1, digit_seen<=0
//   in that same cycle. A sample landing in that cycle is applied after the clear (its bit stays set).
//  Latency: SEG/AN change to flag/capture = 1 (input reg) + SETTLE_CYC cycles; +1 more for frame_valid.
//  Reset mid-frame: partial shadow and digit_seen discarded; value returns to 0; no frame_valid.
//  Glitches shorter than SETTLE_CYC cycles are never sampled.
// STRUCTURE
//  seg7_pkg: SEG encoding localparams (SEG_0..SEG_F, SEG_BLANK=7'h7F) shared with seg7_scan8 and benches.
//  Sub-module seg7_pattern_decode: combinational SEG[6:0] -> {valid, nibble[3:0]}, table above.
//  Top: input reg, settle counter, AN classifier (one-hot/multi-hot/blank, index encode), shadow + seen regs, frame reg.
// TESTING
//  1. Drive seg7_scan8 bits=16'h1234, hold >=1 full scan -> frame_valid pulses, value=32'h0000_1234; repeats each scan.
//  2. Change bits to 16'hABCD mid-scan -> first frame may mix digits; next full frame value=32'h0000_ABCD; no err pulses.
//  3. Force AN=8'hFE, SEG=7'h7F for 10 cycles -> single err_pattern pulse at cycle 1+SETTLE_CYC, digit_seen unchanged.
//  4. Force AN=8'hFC (two digits) stable -> single err_anode pulse; AN=8'hFF stable -> no pulse, no capture.
//  5. Toggle SEG every 2 cycles with SETTLE_CYC=4 -> no captures, no errors, digit_seen stays 0.
//  6. Capture 5 of 8 digits, assert rst=0 one cycle -> value=0, digit_seen=0; next frame needs all 8 digits again.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment encodings (active-low {g,f,e,d,c,b,a}) and scan-capture types.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {AN_BLANK, AN_ONE, AN_MULTI} an_class_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } seg_dec_t;
endpackage

// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if: multiplexed 7-segment scan bus (active-low SEG and AN).
interface seg7_scan_capture_if;
  logic [6:0] SEG;
  logic [7:0] AN;
  modport master (output SEG, AN);
  modport slave (input SEG, AN);
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low segment pattern back to its hex nibble.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);
  always_comb begin
    dec = '{valid: 1'b1, nibble: 4'h0};
    case (seg)
      SEG_0: dec.nibble = 4'h0;
      SEG_1: dec.nibble = 4'h1;
      SEG_2: dec.nibble = 4'h2;
      SEG_3: dec.nibble = 4'h3;
      SEG_4: dec.nibble = 4'h4;
      SEG_5: dec.nibble = 4'h5;
      SEG_6: dec.nibble = 4'h6;
      SEG_7: dec.nibble = 4'h7;
      SEG_8: dec.nibble = 4'h8;
      SEG_9: dec.nibble = 4'h9;
      SEG_A: dec.nibble = 4'hA;
      SEG_B: dec.nibble = 4'hB;
      SEG_C: dec.nibble = 4'hC;
      SEG_D: dec.nibble = 4'hD;
      SEG_E: dec.nibble = 4'hE;
      SEG_F: dec.nibble = 4'hF;
      default: dec.valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: passive monitor that rebuilds the displayed word from a settled SEG/AN scan.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_capture_if.slave  bus,
  output logic [31:0]         value,
  output logic                frame_valid,
  output logic [7:0]          digit_seen,
  output logic                err_pattern,
  output logic                err_anode
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  logic [7:0]    an_q, an_act;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt;
  logic [31:0]   shadow;
  logic [2:0]    idx;
  an_class_t     cls;
  seg_dec_t      dec;
  logic          same, fire, full, in_range, cap;
  seg7_pattern_decode u_dec (.seg(seg_q), .dec(dec));
  assign an_act   = ~an_q;
  assign same     = {bus.AN, bus.SEG} == {an_q, seg_q};
  // fires on the edge that moves the count onto SETTLE_CYC, so once per stable period
  assign fire     = same && cnt == CW'(SETTLE_CYC - 1);
  assign cls      = an_act == 8'd0 ? AN_BLANK : (an_act & (an_act - 8'd1)) == 8'd0 ? AN_ONE : AN_MULTI;
  assign in_range = {1'b0, idx} < 4'(N_DIGITS);
  assign cap      = fire && cls == AN_ONE && in_range && dec.valid;
  assign full     = &digit_seen[N_DIGITS-1:0];
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) if (an_act[i]) idx = 3'(i);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      cnt         <= '0;
      shadow      <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      digit_seen  <= '0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      an_q        <= bus.AN;
      seg_q       <= bus.SEG;
      cnt         <= !same ? '0 : cnt == CW'(SETTLE_CYC) ? cnt : cnt + 1'b1;
      frame_valid <= full;
      err_pattern <= fire && cls == AN_ONE && in_range && !dec.valid;
      err_anode   <= fire && cls == AN_MULTI;
      if (full) value <= shadow;
      // a capture in the frame cycle lands after the clear and survives into the next frame
      digit_seen  <= (full ? 8'd0 : digit_seen) | (cap ? 8'd1 << idx : 8'd0);
      if (cap) shadow[{idx, 2'b00} +: 4] <= dec.nibble;
    end
  end
endmodule
